// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the instruction/data memory arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mem_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;

  // Arbiter FSM states: idle, or memory granted to the fetch or data port.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_e;

  // Identifies a requester, used both as arbitration result and as history.
  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_e;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) to single memory arbiter; d-over-i fixed priority, or round-robin with MEM_ARB_RR_EN.
// Latency: request sampled at edge N drives the strobe in cycle N+1; x_resp is mem_resp passed through combinationally.
// Backpressure: requesters hold req until their resp pulse; one IDLE cycle separates consecutive accesses.
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,

  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_resp,

  input  logic              d_req,
  input  logic              d_we,
  input  logic [MASK_W-1:0] d_wmask,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_resp,

  output logic              mem_read,
  output logic              mem_write,
  output logic [MASK_W-1:0] mem_wmask,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  state_e            state_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic [MASK_W-1:0] mem_wmask_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  grant_e            grant_d;

  // Read data is wired straight from memory to both requesters outside this
  // block; the port exists only so the interface is complete.
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;

`ifdef MEM_ARB_RR_EN
  grant_e last_grant_q;

  // Round-robin: on a tie the requester that did not win last time goes next.
  function automatic grant_e arb_pick(input logic ireq, input logic dreq,
                                      input grant_e last);
    grant_e win;
    if (ireq && dreq) begin
      win = (last == GRANT_D) ? GRANT_I : GRANT_D;
    end else if (dreq) begin
      win = GRANT_D;
    end else begin
      win = GRANT_I;
    end
    return win;
  endfunction

  // Arbitration result for the current cycle (only consumed in IDLE).
  always_comb begin
    grant_d = arb_pick(i_req, d_req, last_grant_q);
  end
`else
  // Fixed priority: data always beats fetch; fetch may starve.
  function automatic grant_e arb_pick(input logic ireq, input logic dreq);
    grant_e win;
    win = GRANT_I;
    if (dreq) begin
      win = GRANT_D;
    end else if (ireq) begin
      win = GRANT_I;
    end
    return win;
  endfunction

  // Arbitration result for the current cycle (only consumed in IDLE).
  always_comb begin
    grant_d = arb_pick(i_req, d_req);
  end
`endif

  // FSM plus registered memory-side outputs; latched values drive memory
  // for the whole grant so requester-side changes cannot disturb it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_wmask_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef MEM_ARB_RR_EN
      last_grant_q <= GRANT_D;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (i_req || d_req) begin
`ifdef MEM_ARB_RR_EN
            last_grant_q <= grant_d;
`endif
            if (grant_d == GRANT_D) begin
              state_q     <= GNT_D;
              mem_addr_q  <= d_addr;
              mem_wdata_q <= d_wdata;
              mem_wmask_q <= d_we ? d_wmask : '0;
              mem_read_q  <= ~d_we;
              mem_write_q <= d_we;
            end else begin
              state_q     <= GNT_I;
              mem_addr_q  <= i_addr;
              mem_wmask_q <= '0;
              mem_read_q  <= 1'b1;
              mem_write_q <= 1'b0;
            end
          end
        end
        GNT_I, GNT_D: begin
          // Completion always returns to IDLE; a waiting request is
          // arbitrated there, never in the completion cycle itself.
          if (mem_resp) begin
            state_q     <= IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_wmask = mem_wmask_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // Completion is forwarded only to the port that owns the memory;
  // a stray mem_resp in IDLE reaches nobody.
  assign i_resp = (state_q == GNT_I) && mem_resp;
  assign d_resp = (state_q == GNT_D) && mem_resp;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, fetch read, data store, address hold, priority, mid-transaction reset.
// Latency: inputs change 1 time unit after the rising edge, outputs are checked 1 unit later.
// Backpressure: memory completion is driven by hand at chosen cycles.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_resp;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_wmask;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_resp;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  int vec_cnt = 0;
  int err_cnt = 0;

  mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_resp    (i_resp),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_wmask   (d_wmask),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_resp    (d_resp),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_wmask (mem_wmask),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_resp  (mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs may then be changed.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_addr;
  logic        exp_i;

  initial begin
    rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_wmask = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_resp = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    #1;
    chk("rst_read",  mem_read,  0);
    chk("rst_write", mem_write, 0);
    chk("rst_addr",  mem_addr,  0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_wmask", mem_wmask, 0);
    chk("rst_iresp", i_resp,    0);
    chk("rst_dresp", d_resp,    0);

    // Fetch read, memory answers 2 cycles after the strobe rises.
    i_req = 1'b1; i_addr = 32'h100;
    cyc(); #1;
    chk("if_read_c1",  mem_read,  1);
    chk("if_addr",     mem_addr,  32'h100);
    chk("if_write",    mem_write, 0);
    chk("if_wmask",    mem_wmask, 0);
    chk("if_iresp_c1", i_resp,    0);
    cyc(); #1;
    chk("if_read_c2",  mem_read,  1);
    chk("if_iresp_c2", i_resp,    0);
    cyc();
    mem_resp = 1'b1; mem_rdata = 32'd1000;
    #1;
    chk("if_read_c3",  mem_read,  1);
    chk("if_iresp_c3", i_resp,    1);
    chk("if_dresp_c3", d_resp,    0);
    cyc();
    mem_resp = 1'b0; i_req = 1'b0;
    #1;
    chk("if_read_idle",  mem_read, 0);
    chk("if_iresp_idle", i_resp,   0);
    chk("if_addr_hold",  mem_addr, 32'h100);

    // Masked store completing in the same cycle as the strobe.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wmask = 4'h3; d_wdata = 32'hDEADBEEF;
    cyc();
    mem_resp = 1'b1;
    #1;
    chk("st_write", mem_write, 1);
    chk("st_read",  mem_read,  0);
    chk("st_wmask", mem_wmask, 4'h3);
    chk("st_wdata", mem_wdata, 32'hDEADBEEF);
    chk("st_addr",  mem_addr,  32'h200);
    chk("st_dresp", d_resp,    1);
    chk("st_iresp", i_resp,    0);
    cyc();
    mem_resp = 1'b0; d_req = 1'b0; d_we = 1'b0;
    #1;
    chk("st_write_idle", mem_write, 0);
    chk("st_dresp_idle", d_resp,    0);
    chk("st_wmask_hold", mem_wmask, 4'h3);

    // Stray completion in IDLE must reach nobody.
    mem_resp = 1'b1;
    #1;
    chk("idle_resp_i", i_resp, 0);
    chk("idle_resp_d", d_resp, 0);
    cyc();
    mem_resp = 1'b0;
    #1;
    chk("idle_resp_read", mem_read, 0);

    // Load whose requester-side address and we change during the grant.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    cyc();
    d_addr = 32'h300; d_we = 1'b1;
    #1;
    chk("ld_addr_c1",  mem_addr,  32'h200);
    chk("ld_read_c1",  mem_read,  1);
    chk("ld_write_c1", mem_write, 0);
    chk("ld_wmask_c1", mem_wmask, 0);
    cyc(); #1;
    chk("ld_addr_c2", mem_addr, 32'h200);
    mem_resp = 1'b1;
    #1;
    chk("ld_dresp", d_resp,   1);
    chk("ld_addr_resp", mem_addr, 32'h200);
    cyc();
    mem_resp = 1'b0; d_req = 1'b0; d_we = 1'b0;
    #1;
    chk("ld_read_idle", mem_read, 0);

    // Both requesters held high for four transactions.
    i_req = 1'b1; i_addr = 32'h400; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
      exp_i = (k % 2 == 0);
`else
      exp_i = 1'b0;
`endif
      exp_addr = exp_i ? 32'h400 : 32'h500;
      cyc(); #1;
      chk($sformatf("pri%0d_addr", k), mem_addr, exp_addr);
      chk($sformatf("pri%0d_read", k), mem_read, 1);
      mem_resp = 1'b1;
      #1;
      chk($sformatf("pri%0d_iresp", k), i_resp, {31'd0, exp_i});
      chk($sformatf("pri%0d_dresp", k), d_resp, {31'd0, ~exp_i});
      cyc();
      mem_resp = 1'b0;
      #1;
      chk($sformatf("pri%0d_gap", k), mem_read, 0);
    end
    i_req = 1'b0; d_req = 1'b0;
    cyc();

    // Reset in the middle of a fetch abandons it silently.
    i_req = 1'b1; i_addr = 32'h140;
    cyc(); #1;
    chk("rstmid_read", mem_read, 1);
    rst = 1'b1; i_req = 1'b0;
    cyc();
    rst = 1'b0;
    #1;
    chk("rstmid_read_after", mem_read, 0);
    chk("rstmid_addr_after", mem_addr, 0);
    chk("rstmid_iresp",      i_resp,   0);
    mem_resp = 1'b1;
    #1;
    chk("rstmid_late_iresp", i_resp, 0);
    chk("rstmid_late_dresp", d_resp, 0);
    cyc();
    mem_resp = 1'b0;
    #1;
    chk("rstmid_late_read", mem_read, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
